// File: rtl/memory_interface_pkg.sv
// Shared definitions for the memory interface: funct3 access codes, FSM state
// encoding and the reset-time NOP instruction.
package memory_interface_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/memory_interface_align.sv
// Byte-lane helper: store strobes and replicated write data, load extension
// and the alignment check for a given access size and byte offset.
module lsu_align
   import memory_interface_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] write_data,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Load lane selection and sign/zero extension
   always_comb begin
      case (off)
         2'd0:    byte_s = bus_rdata[7:0];
         2'd1:    byte_s = bus_rdata[15:8];
         2'd2:    byte_s = bus_rdata[23:16];
         2'd3:    byte_s = bus_rdata[31:24];
         default: byte_s = bus_rdata[7:0];
      endcase
      half_s = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (funct3)
         F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
         F3_LBU:  load_data = {24'd0, byte_s};
         F3_LH:   load_data = {{16{half_s[15]}}, half_s};
         F3_LHU:  load_data = {16'd0, half_s};
         default: load_data = bus_rdata;
      endcase
   end

   // Store lanes and alignment; size comes from funct3[1:0] for loads and stores alike
   always_comb begin
      case (funct3[1:0])
         F3_SB[1:0]: begin
            wstrb      = 4'b0001 << off;
            wdata      = {4{write_data[7:0]}};
            misaligned = 1'b0;
         end
         F3_SH[1:0]: begin
            wstrb      = 4'b0011 << off;
            wdata      = {2{write_data[15:0]}};
            misaligned = off[0];
         end
         F3_SW[1:0]: begin
            wstrb      = 4'b1111;
            wdata      = write_data;
            misaligned = (off != 2'b00);
         end
         default: begin
            wstrb      = 4'b1111;
            wdata      = write_data;
            misaligned = (off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/memory_interface.sv
// Converts one-cycle fetch/load/store strobes from the control unit into a
// valid/ready bus transaction and holds instr, old_pc and load data.
module memory_interface
   import memory_interface_pkg::*;
#(
   parameter int unsigned TIMEOUT     = 255,
   parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        access_valid,
   input  logic        adrsource,
   input  logic        memwrite,
   input  logic        irwrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] pc,
   input  logic [31:0] alu_result,
   input  logic [31:0] write_data,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready,
   output logic [31:0] instr,
   output logic [31:0] old_pc,
   output logic [31:0] data,
   output logic        busy,
   output logic        done,
   output logic        misaligned,
   output logic        bus_error
);

   state_t      state_r, state_n;
   logic [31:0] addr_s;
   logic [2:0]  req_funct3_s;
   logic [2:0]  al_funct3_s;
   logic [1:0]  al_off_s;
   logic [3:0]  al_wstrb_s;
   logic [31:0] al_wdata_s, al_load_s;
   logic        al_mis_s;
   logic        accept_s, capture_s, timeout_s;

   logic [2:0]  funct3_r;
   logic [1:0]  off_r;
   logic        memwrite_r, irwrite_r;
   logic [31:0] pend_pc_r, count_r;
   logic        bus_valid_r, bus_we_r, busy_r, done_r, misaligned_r, bus_error_r;
   logic [31:0] bus_addr_r, bus_wdata_r, instr_r, old_pc_r, data_r;
   logic [3:0]  bus_wstrb_r;

   // Request decode; the aligner sees live request fields in IDLE, held fields otherwise
   always_comb begin
      addr_s       = adrsource ? alu_result : pc;
      req_funct3_s = (irwrite && !memwrite) ? F3_LW : funct3;
      if (state_r == ST_IDLE) begin
         al_funct3_s = req_funct3_s;
         al_off_s    = addr_s[1:0];
      end else begin
         al_funct3_s = funct3_r;
         al_off_s    = off_r;
      end
   end

   lsu_align u_align (
      .funct3     (al_funct3_s),
      .off        (al_off_s),
      .write_data (write_data),
      .bus_rdata  (bus_rdata),
      .wstrb      (al_wstrb_s),
      .wdata      (al_wdata_s),
      .load_data  (al_load_s),
      .misaligned (al_mis_s)
   );

   // Next-state logic
   always_comb begin
      state_n   = state_r;
      accept_s  = 1'b0;
      capture_s = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (access_valid) begin
               accept_s = 1'b1;
               state_n  = al_mis_s ? ST_DONE : ST_REQ;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus_ready) begin
               capture_s = !memwrite_r;
               state_n   = ST_DONE;
            end else if ((TIMEOUT != 32'd0) && (count_r + 32'd1 == TIMEOUT)) begin
               timeout_s = 1'b1;
               state_n   = ST_DONE;
            end else begin
               state_n = ST_REQ;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // State, bus outputs and captured results
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         bus_valid_r  <= 1'b0;
         bus_we_r     <= 1'b0;
         bus_wstrb_r  <= 4'b0000;
         bus_addr_r   <= 32'd0;
         bus_wdata_r  <= 32'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         misaligned_r <= 1'b0;
         bus_error_r  <= 1'b0;
         instr_r      <= RESET_INSTR;
         old_pc_r     <= 32'd0;
         data_r       <= 32'd0;
         funct3_r     <= 3'd0;
         off_r        <= 2'd0;
         memwrite_r   <= 1'b0;
         irwrite_r    <= 1'b0;
         pend_pc_r    <= 32'd0;
         count_r      <= 32'd0;
      end else begin
         state_r     <= state_n;
         bus_valid_r <= (state_n == ST_REQ);
         done_r      <= (state_n == ST_DONE);
         busy_r      <= (state_n != ST_IDLE);
         if (accept_s) begin
            bus_addr_r   <= {addr_s[31:2], 2'b00};
            bus_we_r     <= memwrite && !al_mis_s;
            bus_wstrb_r  <= (memwrite && !al_mis_s) ? al_wstrb_s : 4'b0000;
            bus_wdata_r  <= memwrite ? al_wdata_s : 32'd0;
            funct3_r     <= req_funct3_s;
            off_r        <= addr_s[1:0];
            memwrite_r   <= memwrite;
            irwrite_r    <= irwrite;
            pend_pc_r    <= pc;
            misaligned_r <= al_mis_s;
            bus_error_r  <= 1'b0;
            count_r      <= 32'd0;
         end else if (state_r == ST_REQ) begin
            if (state_n != ST_REQ) begin
               bus_we_r    <= 1'b0;
               bus_wstrb_r <= 4'b0000;
            end
            if (capture_s) begin
               if (irwrite_r) begin
                  instr_r  <= bus_rdata;
                  old_pc_r <= pend_pc_r;
               end else begin
                  data_r <= al_load_s;
               end
            end
            if (timeout_s) begin
               bus_error_r <= 1'b1;
            end
            if (!bus_ready) begin
               count_r <= count_r + 32'd1;
            end
         end
      end
   end

   assign bus_valid  = bus_valid_r;
   assign bus_we     = bus_we_r;
   assign bus_addr   = bus_addr_r;
   assign bus_wdata  = bus_wdata_r;
   assign bus_wstrb  = bus_wstrb_r;
   assign instr      = instr_r;
   assign old_pc     = old_pc_r;
   assign data       = data_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign misaligned = misaligned_r;
   assign bus_error  = bus_error_r;

endmodule

// File: tb/tb_memory_interface.sv
// Directed and randomized checks of memory_interface against a byte-lane
// arithmetic reference model.
module tb_memory_interface;

   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        access_valid, adrsource, memwrite, irwrite;
   logic [2:0]  funct3;
   logic [31:0] pc, alu_result, write_data;
   logic        bus_valid, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   logic [31:0] instr, old_pc, data;
   logic        busy, done, misaligned, bus_error;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   logic [31:0] exp_instr, exp_old_pc, exp_data;
   logic        exp_mis, exp_err;

   memory_interface #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .access_valid(access_valid), .adrsource(adrsource),
      .memwrite(memwrite), .irwrite(irwrite), .funct3(funct3), .pc(pc),
      .alu_result(alu_result), .write_data(write_data), .bus_valid(bus_valid),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready), .instr(instr), .old_pc(old_pc),
      .data(data), .busy(busy), .done(done), .misaligned(misaligned), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      else if (f3[1:0] == 2'b01) return 2;
      else return 4;
   endfunction

   function automatic logic [3:0] model_wstrb(input int size, input int off);
      logic [3:0] w;
      for (int i = 0; i < 4; i++) w[i] = (i >= off) && (i < off + size);
      return w;
   endfunction

   function automatic logic [31:0] model_wdata(input int size, input logic [31:0] wd);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
      int size;
      longint v, span;
      size = acc_size(f3);
      span = longint'(1) << (8 * size);
      v = longint'(rd >> (8 * off)) % span;
      if (size < 4 && f3[2] == 1'b0 && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   task automatic check_results(input string tag);
      chk({tag, ".data"}, data, exp_data);
      chk({tag, ".instr"}, instr, exp_instr);
      chk({tag, ".old_pc"}, old_pc, exp_old_pc);
      chk({tag, ".misaligned"}, 32'(misaligned), 32'(exp_mis));
      chk({tag, ".bus_error"}, 32'(bus_error), 32'(exp_err));
   endtask

   // One complete access: drive, play bus slave for `waits` cycles, check timing and results
   task automatic access(input string tag, input bit src, input bit mw, input bit irw,
                         input logic [2:0] f3, input logic [31:0] pc_v, input logic [31:0] alu_v,
                         input logic [31:0] wd_v, input logic [31:0] rd_v, input int waits,
                         input bit poke);
      logic [31:0] a;
      int off, size, vcyc;
      bit fetch, mis, tmo;
      a     = src ? alu_v : pc_v;
      off   = int'(a[1:0]);
      fetch = irw && !mw;
      size  = fetch ? 4 : acc_size(f3);
      mis   = (off % size) != 0;
      tmo   = !mis && (waits >= TB_TIMEOUT);
      vcyc  = tmo ? TB_TIMEOUT : waits + 1;
      @(negedge clk);
      adrsource = src; memwrite = mw; irwrite = irw; funct3 = f3;
      pc = pc_v; alu_result = alu_v; write_data = wd_v; access_valid = 1'b1;
      @(negedge clk);
      access_valid = 1'b0;
      pc = $urandom; alu_result = $urandom; write_data = $urandom; funct3 = 3'($urandom);
      if (!mis) begin
         for (int c = 0; c < vcyc; c++) begin
            chk({tag, ".bus_valid"}, 32'(bus_valid), 32'd1);
            chk({tag, ".done_early"}, 32'(done), 32'd0);
            chk({tag, ".bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
            chk({tag, ".bus_we"}, 32'(bus_we), 32'(mw));
            chk({tag, ".bus_wstrb"}, 32'(bus_wstrb), mw ? 32'(model_wstrb(size, off)) : 32'd0);
            if (mw) chk({tag, ".bus_wdata"}, bus_wdata, model_wdata(size, wd_v));
            bus_ready    = !tmo && (c == waits);
            bus_rdata    = bus_ready ? rd_v : $urandom;
            access_valid = poke && (c == 1);
            @(negedge clk);
         end
         bus_ready    = 1'b0;
         access_valid = 1'b0;
      end
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".busy_done"}, 32'(busy), 32'd1);
      chk({tag, ".bus_valid_done"}, 32'(bus_valid), 32'd0);
      exp_mis = mis;
      exp_err = tmo;
      if (!mis && !tmo && !mw) begin
         if (fetch) begin
            exp_instr  = rd_v;
            exp_old_pc = pc_v;
         end else begin
            exp_data = model_load(f3, off, rd_v);
         end
      end
      check_results(tag);
      access_valid = poke;
      @(negedge clk);
      access_valid = 1'b0;
      chk({tag, ".done_clear"}, 32'(done), 32'd0);
      chk({tag, ".idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b0; access_valid = 1'b0; adrsource = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
      funct3 = 3'd0; pc = 32'd0; alu_result = 32'd0; write_data = 32'd0;
      bus_rdata = 32'd0; bus_ready = 1'b0;
      exp_instr = 32'h0000_0013; exp_old_pc = 32'd0; exp_data = 32'd0;
      exp_mis = 1'b0; exp_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.bus_valid", 32'(bus_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.bus_addr", bus_addr, 32'd0);
      chk("rst.bus_wstrb", 32'(bus_wstrb), 32'd0);
      check_results("rst");
      reset = 1'b1;

      access("fetch", 1'b0, 1'b0, 1'b1, 3'b000, 32'h10, 32'h0, 32'h0, 32'h0050_0093, 1, 1'b0);
      access("sb", 1'b1, 1'b1, 1'b0, 3'b000, 32'h0, 32'h103, 32'h1234_56AB, 32'h0, 0, 1'b0);
      access("lb", 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h102, 32'h0, 32'h0080_FF00, 0, 1'b0);
      access("lbu", 1'b1, 1'b0, 1'b0, 3'b100, 32'h0, 32'h102, 32'h0, 32'h0080_FF00, 0, 1'b0);
      access("lh", 1'b1, 1'b0, 1'b0, 3'b001, 32'h0, 32'h102, 32'h0, 32'h0080_FF00, 0, 1'b0);
      access("lw_mis", 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h102, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      access("lw_ok", 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h100, 32'h0, 32'hCAFE_F00D, 2, 1'b0);
      access("sh_hi", 1'b1, 1'b1, 1'b0, 3'b001, 32'h0, 32'h202, 32'hAAAA_5A7E, 32'h0, 1, 1'b0);
      access("timeout", 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h300, 32'h0, 32'h1111_2222, 9, 1'b1);
      access("after_to", 1'b0, 1'b0, 1'b1, 3'b111, 32'h24, 32'h0, 32'h0, 32'h0000_0513, 0, 1'b1);

      // Reset in the second REQ cycle discards the fetch
      @(negedge clk);
      adrsource = 1'b0; memwrite = 1'b0; irwrite = 1'b1; pc = 32'h40; access_valid = 1'b1;
      @(negedge clk);
      access_valid = 1'b0;
      chk("mid.req1_valid", 32'(bus_valid), 32'd1);
      @(negedge clk);
      chk("mid.req2_valid", 32'(bus_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid.bus_valid", 32'(bus_valid), 32'd0);
      chk("mid.busy", 32'(busy), 32'd0);
      exp_instr = 32'h0000_0013; exp_old_pc = 32'd0; exp_data = 32'd0;
      exp_mis = 1'b0; exp_err = 1'b0;
      check_results("mid");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid.idle", 32'(busy), 32'd0);
      access("refetch", 1'b0, 1'b0, 1'b1, 3'b000, 32'h44, 32'h0, 32'h0, 32'h00A0_0113, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         access("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom,
                $urandom, $urandom, $urandom, int'($urandom_range(0, 5)), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
